multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-style datapath: PC, IR, MDR, A, B, ALUOut and a 32x32
// register file, steered cycle by cycle by an external controller through
// the *_ctrl lines. Memory is word addressed; PC increments by one.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWriteCond_ctrl,
  input  logic        PCWrite_ctrl,
  input  logic        IorD_ctrl,
  input  logic        MemRead_ctrl,
  input  logic        MemWrite_ctrl,
  input  logic        MemtoReg_ctrl,
  input  logic        IRWrite_ctrl,
  input  logic        BEQ_ctrl,
  input  logic        ALUSrcA_ctrl,
  input  logic        RegWrite_ctrl,
  input  logic        RegDst_ctrl,
  input  logic [1:0]  PCSrc_ctrl,
  input  logic [3:0]  ALUOP_ctrl,
  input  logic [1:0]  ALUSrcB_ctrl,
  output logic [5:0]  opcode_out,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RIDX = 5;
  localparam int unsigned OPW  = 6;
  localparam int unsigned IMMW = 16;
  localparam int unsigned TGTW = 26;

  // ALU functions, encoded to match op[2:0] so the opcode can select directly.
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_NOR   = 3'b101,
    ALU_SLT   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_fn_e;

  // Architectural state
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_mdr;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_aluout;
  logic [XLEN-1:0] r_rf [NREG];

  // Instruction fields
  logic [OPW-1:0]  w_op;
  logic [RIDX-1:0] w_rs;
  logic [RIDX-1:0] w_rt;
  logic [RIDX-1:0] w_rd;
  logic [IMMW-1:0] w_imm;
  logic [TGTW-1:0] w_target;
  logic [XLEN-1:0] w_imm_sext;

  // Datapath nets
  logic [XLEN-1:0] w_rs_data;
  logic [XLEN-1:0] w_rt_data;
  logic [XLEN-1:0] w_alu_a;
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_alu_result;
  alu_fn_e         w_alu_fn;
  logic            w_slt;
  logic            w_zero;
  logic [XLEN-1:0] w_pc_next;
  logic            w_pc_we;
  logic [RIDX-1:0] w_wr_idx;
  logic [XLEN-1:0] w_wr_data;
  logic            w_rf_we;

  // Field decode from the instruction register
  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_imm      = r_ir[15:0];
  assign w_target   = r_ir[25:0];
  assign w_imm_sext = {{(XLEN-IMMW){w_imm[IMMW-1]}}, w_imm};

  // Register file read ports; r0 is hard-wired to zero
  assign w_rs_data = (w_rs == '0) ? '0 : r_rf[w_rs];
  assign w_rt_data = (w_rt == '0) ? '0 : r_rf[w_rt];

  // ALU operand A: PC or register A
  always_comb begin
    w_alu_a = r_pc;
    if (ALUSrcA_ctrl) begin
      w_alu_a = r_a;
    end
  end

  // ALU operand B: register B, PC step of one word, or sign-extended immediate
  always_comb begin
    w_alu_b = r_b;
    case (ALUSrcB_ctrl)
      2'b00:   w_alu_b = r_b;
      2'b01:   w_alu_b = XLEN'(1);
      default: w_alu_b = w_imm_sext;
    endcase
  end

  // ALU function: fixed add/sub for address and branch work, opcode-driven for R-type
  always_comb begin
    w_alu_fn = ALU_ADD;
    case (ALUOP_ctrl)
      4'b0000:          w_alu_fn = ALU_ADD;
      4'b0001:          w_alu_fn = ALU_SUB;
      4'b1000, 4'b0010: w_alu_fn = alu_fn_e'(w_op[2:0]);
      default:          w_alu_fn = ALU_ADD;
    endcase
  end

  assign w_slt = ($signed(w_alu_a) < $signed(w_alu_b));

  // ALU; all arithmetic wraps modulo 2^32
  always_comb begin
    w_alu_result = '0;
    case (w_alu_fn)
      ALU_ADD:   w_alu_result = w_alu_a + w_alu_b;
      ALU_SUB:   w_alu_result = w_alu_a - w_alu_b;
      ALU_AND:   w_alu_result = w_alu_a & w_alu_b;
      ALU_OR:    w_alu_result = w_alu_a | w_alu_b;
      ALU_XOR:   w_alu_result = w_alu_a ^ w_alu_b;
      ALU_NOR:   w_alu_result = ~(w_alu_a | w_alu_b);
      ALU_SLT:   w_alu_result = XLEN'(w_slt);
      ALU_PASSB: w_alu_result = w_alu_b;
      default:   w_alu_result = '0;
    endcase
  end

  assign w_zero = (w_alu_result == '0);

  // Next-PC source: ALU result, latched ALUOut, jump target, or hold
  always_comb begin
    w_pc_next = r_pc;
    case (PCSrc_ctrl)
      2'b00:   w_pc_next = w_alu_result;
      2'b01:   w_pc_next = r_aluout;
      2'b10:   w_pc_next = {r_pc[XLEN-1:TGTW], w_target};
      default: w_pc_next = r_pc;
    endcase
  end

  // BEQ_ctrl picks the polarity of zero that takes a conditional branch
  assign w_pc_we = PCWrite_ctrl | (PCWriteCond_ctrl & (w_zero == BEQ_ctrl));

  // Register write-back target and data; writes to r0 are dropped
  assign w_wr_idx  = RegDst_ctrl ? w_rd : w_rt;
  assign w_wr_data = MemtoReg_ctrl ? r_mdr : r_aluout;
  assign w_rf_we   = RegWrite_ctrl & (w_wr_idx != '0);

  // Program counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_pc_we) begin
      r_pc <= w_pc_next;
    end
  end

  // Instruction register, loaded only on fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ir <= '0;
    end else if (IRWrite_ctrl) begin
      r_ir <= mem_rdata;
    end
  end

  // Pipeline-style holding registers, refreshed every cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      r_mdr    <= mem_rdata;
      r_a      <= w_rs_data;
      r_b      <= w_rt_data;
      r_aluout <= w_alu_result;
    end
  end

  // Register file storage; a write is seen by the read ports next cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rf <= '{default: '0};
    end else if (w_rf_we) begin
      r_rf[w_wr_idx] <= w_wr_data;
    end
  end

  // Controller and memory facing outputs; strobes and opcode squashed in reset
  assign opcode_out = reset ? '0 : w_op;
  assign mem_addr   = IorD_ctrl ? r_aluout : r_pc;
  assign mem_wdata  = r_b;
  assign mem_read   = MemRead_ctrl & ~reset;
  assign mem_write  = MemWrite_ctrl & ~reset;
  assign pc_out     = r_pc;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: directed instruction sequences with literal
// expectations, then randomized control/memory traffic against a behavioural
// model of the architectural state, outputs compared every cycle.
module tb_multicycle_datapath;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic       rst;
    logic       pcwc;
    logic       pcw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       m2r;
    logic       irw;
    logic       beq;
    logic       srca;
    logic       rw;
    logic       rdst;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic [1:0] srcb;
  } ctl_t;

  localparam int CW = $bits(ctl_t);

  logic        clock = 1'b0;
  logic        reset;
  logic        PCWriteCond_ctrl, PCWrite_ctrl, IorD_ctrl, MemRead_ctrl, MemWrite_ctrl;
  logic        MemtoReg_ctrl, IRWrite_ctrl, BEQ_ctrl, ALUSrcA_ctrl, RegWrite_ctrl, RegDst_ctrl;
  logic [1:0]  PCSrc_ctrl;
  logic [3:0]  ALUOP_ctrl;
  logic [1:0]  ALUSrcB_ctrl;
  logic [5:0]  opcode_out;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic        mem_read, mem_write;

  multicycle_datapath #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .PCWriteCond_ctrl(PCWriteCond_ctrl), .PCWrite_ctrl(PCWrite_ctrl),
    .IorD_ctrl(IorD_ctrl), .MemRead_ctrl(MemRead_ctrl), .MemWrite_ctrl(MemWrite_ctrl),
    .MemtoReg_ctrl(MemtoReg_ctrl), .IRWrite_ctrl(IRWrite_ctrl), .BEQ_ctrl(BEQ_ctrl),
    .ALUSrcA_ctrl(ALUSrcA_ctrl), .RegWrite_ctrl(RegWrite_ctrl), .RegDst_ctrl(RegDst_ctrl),
    .PCSrc_ctrl(PCSrc_ctrl), .ALUOP_ctrl(ALUOP_ctrl), .ALUSrcB_ctrl(ALUSrcB_ctrl),
    .opcode_out(opcode_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .pc_out(pc_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model of the machine's architectural state
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_alo;
  logic [31:0] m_rf [32];
  ctl_t        cur_c;
  logic [31:0] cur_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ALU behaviour described as a table of operations by name
  function automatic logic [31:0] m_alu_calc(input logic [3:0] aop, input logic [5:0] op,
                                             input logic [31:0] x, input logic [31:0] y);
    int k;
    if (aop == 4'd1) k = 1;
    else if (aop == 4'd8 || aop == 4'd2) k = int'(op[2:0]);
    else k = 0;
    case (k)
      0: return x + y;
      1: return x - y;
      2: return x & y;
      3: return x | y;
      4: return x ^ y;
      5: return ~(x | y);
      6: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return y;
    endcase
  endfunction

  // Advance the model by one clock edge given the controls held during the cycle
  task automatic model_edge(input ctl_t c, input logic [31:0] rd);
    logic [31:0] x, y, res, imm, npc, na, nb, wd;
    logic [4:0]  dst;
    logic        take;
    if (c.rst) begin
      m_pc = RESET_PC; m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_alo = '0;
      foreach (m_rf[i]) m_rf[i] = '0;
      return;
    end
    imm = 32'($signed(m_ir[15:0]));
    x = c.srca ? m_a : m_pc;
    case (c.srcb)
      2'b00:   y = m_b;
      2'b01:   y = 32'd1;
      default: y = imm;
    endcase
    res = m_alu_calc(c.aluop, m_ir[31:26], x, y);
    take = c.pcw || (c.pcwc && ((res == 32'd0) == c.beq));
    case (c.pcsrc)
      2'b00:   npc = res;
      2'b01:   npc = m_alo;
      2'b10:   npc = {m_pc[31:26], m_ir[25:0]};
      default: npc = m_pc;
    endcase
    na  = m_rf[m_ir[25:21]];
    nb  = m_rf[m_ir[20:16]];
    dst = c.rdst ? m_ir[15:11] : m_ir[20:16];
    wd  = c.m2r ? m_mdr : m_alo;
    if (c.rw && dst != 5'd0) m_rf[dst] = wd;
    if (take) m_pc = npc;
    if (c.irw) m_ir = rd;
    m_a = na; m_b = nb; m_alo = res; m_mdr = rd;
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare_outputs();
    chk("opcode_out", 32'(opcode_out), cur_c.rst ? 32'd0 : 32'(m_ir[31:26]));
    chk("mem_addr",   mem_addr,  cur_c.iord ? m_alo : m_pc);
    chk("mem_wdata",  mem_wdata, m_b);
    chk("mem_read",   32'(mem_read),  32'(cur_c.mrd & ~cur_c.rst));
    chk("mem_write",  32'(mem_write), 32'(cur_c.mwr & ~cur_c.rst));
    chk("pc_out",     pc_out, m_pc);
  endtask

  task automatic drive(input ctl_t c, input logic [31:0] rd);
    reset = c.rst; PCWriteCond_ctrl = c.pcwc; PCWrite_ctrl = c.pcw; IorD_ctrl = c.iord;
    MemRead_ctrl = c.mrd; MemWrite_ctrl = c.mwr; MemtoReg_ctrl = c.m2r;
    IRWrite_ctrl = c.irw; BEQ_ctrl = c.beq; ALUSrcA_ctrl = c.srca;
    RegWrite_ctrl = c.rw; RegDst_ctrl = c.rdst; PCSrc_ctrl = c.pcsrc;
    ALUOP_ctrl = c.aluop; ALUSrcB_ctrl = c.srcb; mem_rdata = rd;
    cur_c = c; cur_rd = rd;
    #1;
    if (chk_en) compare_outputs();
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge(cur_c, cur_rd);
    #1;
  endtask

  task automatic cyc(input ctl_t c, input logic [31:0] rd);
    drive(c, rd);
    tick();
  endtask

  function automatic ctl_t idle();
    ctl_t c;
    c = '0;
    return c;
  endfunction

  function automatic ctl_t rst_ctl();
    ctl_t c;
    c = '0;
    c.rst = 1'b1;
    return c;
  endfunction

  task automatic load_ir(input logic [31:0] instr);
    ctl_t c;
    c = idle(); c.irw = 1'b1;
    cyc(c, instr);
  endtask

  // Write a register through the MDR path: IR(rt=idx), MDR<=val, write back
  task automatic load_reg(input logic [4:0] idx, input logic [31:0] val);
    ctl_t c;
    load_ir({6'd0, 5'd0, idx, 16'd0});
    cyc(idle(), val);
    c = idle(); c.rw = 1'b1; c.m2r = 1'b1;
    cyc(c, 32'd0);
  endtask

  // Observe a register through B -> mem_wdata
  task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
    load_ir({6'd0, 5'd0, idx, 16'd0});
    cyc(idle(), 32'd0);
    val = mem_wdata;
  endtask

  task automatic set_pc_jump(input logic [25:0] tgt);
    ctl_t c;
    load_ir({6'h02, tgt});
    c = idle(); c.pcw = 1'b1; c.pcsrc = 2'b10;
    cyc(c, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] instr);
    ctl_t c;
    c = idle(); c.irw = 1'b1; c.pcw = 1'b1; c.mrd = 1'b1; c.srcb = 2'b01; c.pcsrc = 2'b00;
    cyc(c, instr);
  endtask

  task automatic branch_case(input logic beq, input logic [31:0] exp_pc, input string nm);
    ctl_t c;
    cyc(rst_ctl(), 32'd0);
    load_reg(5'd1, 32'd9);
    load_reg(5'd2, 32'd9);
    set_pc_jump(26'd3);
    fetch({6'h04, 5'd1, 5'd2, 16'hFFFE});
    chk({nm, "_pc_after_fetch"}, pc_out, 32'd4);
    c = idle(); c.srcb = 2'b11;
    cyc(c, 32'd0);
    c = idle(); c.srca = 1'b1; c.aluop = 4'b0001; c.pcwc = 1'b1; c.beq = beq; c.pcsrc = 2'b01;
    cyc(c, 32'd0);
    chk({nm, "_pc"}, pc_out, exp_pc);
  endtask

  initial begin
    ctl_t c;
    logic [31:0] v;
    logic [CW-1:0] bits;

    // Initial reset, no checks until state is defined
    cyc(rst_ctl(), 32'd0);
    chk_en = 1'b1;

    // Strobes and opcode forced low while reset is held
    c = rst_ctl(); c.mrd = 1'b1; c.mwr = 1'b1;
    drive(c, 32'hFFFF_FFFF);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_opcode", 32'(opcode_out), 32'd0);
    tick();
    chk("rst_pc", pc_out, RESET_PC);

    // Fetch
    c = idle(); c.irw = 1'b1; c.pcw = 1'b1; c.mrd = 1'b1; c.srcb = 2'b01;
    drive(c, 32'hFC22_0005);
    chk("post_rst_opcode", 32'(opcode_out), 32'd0);
    chk("fetch_mem_read", 32'(mem_read), 32'd1);
    tick();
    chk("fetch_pc", pc_out, 32'd1);
    chk("fetch_opcode", 32'(opcode_out), 32'h3F);

    // R-type sub: r3 = r1 - r2
    cyc(rst_ctl(), 32'd0);
    load_reg(5'd1, 32'd7);
    load_reg(5'd2, 32'd5);
    load_ir({6'b010001, 5'd1, 5'd2, 5'd3, 11'd0});
    cyc(idle(), 32'd0);
    c = idle(); c.srca = 1'b1; c.aluop = 4'b1000;
    cyc(c, 32'd0);
    c = idle(); c.rw = 1'b1; c.rdst = 1'b1; c.iord = 1'b1;
    drive(c, 32'd0);
    chk("rtype_aluout", mem_addr, 32'd2);
    tick();
    read_reg(5'd3, v);
    chk("rtype_r3", v, 32'd2);

    // Reset in the middle of an ALU cycle with RegWrite pending
    load_ir({6'b010001, 5'd1, 5'd2, 5'd3, 11'd0});
    cyc(idle(), 32'd0);
    c = rst_ctl(); c.srca = 1'b1; c.aluop = 4'b1000; c.rw = 1'b1; c.rdst = 1'b1; c.pcw = 1'b1;
    c.mwr = 1'b1;
    drive(c, 32'd0);
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    tick();
    chk("midrst_pc", pc_out, RESET_PC);
    read_reg(5'd1, v); chk("midrst_r1", v, 32'd0);
    read_reg(5'd2, v); chk("midrst_r2", v, 32'd0);
    read_reg(5'd3, v); chk("midrst_r3", v, 32'd0);

    // Branch taken (BEQ) and not taken (BNE) on equal operands
    branch_case(1'b1, 32'd2, "beq");
    branch_case(1'b0, 32'd4, "bne");

    // Store word immediate: mem[r1+3] <= r2
    cyc(rst_ctl(), 32'd0);
    load_reg(5'd1, 32'd10);
    load_reg(5'd2, 32'hDEAD_BEEF);
    load_ir({6'h2B, 5'd1, 5'd2, 16'd3});
    cyc(idle(), 32'd0);
    c = idle(); c.srca = 1'b1; c.srcb = 2'b10;
    cyc(c, 32'd0);
    c = idle(); c.iord = 1'b1; c.mwr = 1'b1;
    drive(c, 32'd0);
    chk("sw_addr", mem_addr, 32'd13);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_write", 32'(mem_write), 32'd1);
    tick();

    // Load word immediate: r4 <= mem[r1+3]
    load_ir({6'h23, 5'd1, 5'd4, 16'd3});
    cyc(idle(), 32'd0);
    c = idle(); c.srca = 1'b1; c.srcb = 2'b10;
    cyc(c, 32'd0);
    c = idle(); c.iord = 1'b1; c.mrd = 1'b1;
    drive(c, 32'hDEAD_BEEF);
    chk("lw_addr", mem_addr, 32'd13);
    tick();
    c = idle(); c.rw = 1'b1; c.m2r = 1'b1;
    cyc(c, 32'd0);
    read_reg(5'd4, v);
    chk("lw_r4", v, 32'hDEAD_BEEF);

    // Jump keeps PC[31:26]; first steer PC to 0x0400_0010 through the ALU
    cyc(rst_ctl(), 32'd0);
    load_reg(5'd5, 32'h0400_0010);
    load_ir({6'h00, 5'd5, 5'd0, 16'd0});
    cyc(idle(), 32'd0);
    c = idle(); c.srca = 1'b1; c.pcw = 1'b1;
    cyc(c, 32'd0);
    chk("jump_setup_pc", pc_out, 32'h0400_0010);
    set_pc_jump(26'h000_0020);
    chk("jump_pc", pc_out, 32'h0400_0020);

    // r0 ignores writes
    load_reg(5'd0, 32'h1234_5678);
    read_reg(5'd0, v);
    chk("r0_zero", v, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      bits = CW'($urandom);
      c = ctl_t'(bits);
      c.rst = ($urandom_range(0, 40) == 0);
      case ($urandom_range(0, 4))
        0: c.aluop = 4'b1000;
        1: c.aluop = 4'b0010;
        2: c.aluop = 4'b0001;
        3: c.aluop = 4'b0000;
        default: ;
      endcase
      if ($urandom_range(0, 2) != 0) c.pcw = 1'b0;
      cyc(c, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
